// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master / one-slave Wishbone classic arbiter with CYC lock,
//            round-robin tie break and an unanswered-strobe watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int datawidth = 32,
    parameter int addrwidth = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [addrwidth-1:0] m0_adr_i,
    input  logic [datawidth-1:0] m0_dat_i,
    output logic [datawidth-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [addrwidth-1:0] m1_adr_i,
    input  logic [datawidth-1:0] m1_dat_i,
    output logic [datawidth-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [addrwidth-1:0] s_adr_o,
    output logic [datawidth-1:0] s_dat_o,
    input  logic [datawidth-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [1:0]           grant,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_own0;
    logic   w_own1;
    logic   w_wd_err;
    logic   w_term_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // r_last names the most recent owner; on a tie the other master wins.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last ? OWN0 : OWN1;
                else if (m0_cyc_i)
                    w_state_nxt = OWN0;
                else if (m1_cyc_i)
                    w_state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);
    assign grant  = {w_own1, w_own0};

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;
    assign w_term_err = s_err_i | w_wd_err;
    assign m0_ack_o   = s_ack_i & w_own0 & ~s_err_i;
    assign m1_ack_o   = s_ack_i & w_own1 & ~s_err_i;
    assign m0_err_o   = w_term_err & w_own0;
    assign m1_err_o   = w_term_err & w_own1;
    assign timeout_o  = w_wd_err;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int c_cnt_w = $clog2(TIMEOUT + 1);
            logic [c_cnt_w-1:0] r_cnt;

            // A slave answer in the expiry cycle takes precedence over the timeout.
            assign w_wd_err = s_stb_o && !s_ack_i && !s_err_i
                              && (r_cnt == c_cnt_w'(TIMEOUT));

            always_ff @(posedge clk) begin
                if (rst)
                    r_cnt <= '0;
                else if (!s_stb_o || s_ack_i || s_err_i || w_wd_err
                         || (w_state_nxt != r_state))
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end else begin : g_no_wd
            assign w_wd_err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// Testbench for wb_arbiter2: directed vectors, expected outputs queued per
// cycle by the driver and checked by an independent negedge monitor.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] s_dat_in;
    logic        s_ack, s_err;

    logic [31:0] m0_rd, m1_rd, s_adr, s_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, tmo;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    logic [31:0] z_m0_rd, z_m1_rd, z_s_adr, z_s_wd;
    logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
    logic        z_s_cyc, z_s_stb, z_s_we, z_tmo;
    logic [3:0]  z_s_sel;
    logic [1:0]  z_grant;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [1:0]  grant;
        logic        s_cyc;
        logic        a0, e0, a1, e1, t, ez;
        bit          adr_en;
        logic [31:0] adr;
        bit          dat_en;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];

    wb_arbiter2 #(.datawidth(32), .addrwidth(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rd),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rd),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_dat_in),
        .s_ack_i(s_ack), .s_err_i(s_err), .grant(grant), .timeout_o(tmo)
    );

    wb_arbiter2 #(.datawidth(32), .addrwidth(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(z_m0_rd),
        .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(z_m1_rd),
        .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
        .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_sel_o(z_s_sel),
        .s_adr_o(z_s_adr), .s_dat_o(z_s_wd), .s_dat_i(s_dat_in),
        .s_ack_i(s_ack), .s_err_i(s_err), .grant(z_grant), .timeout_o(z_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "grant",  {30'd0, grant},  {30'd0, e.grant});
            chk(e.name, "s_cyc",  {31'd0, s_cyc},  {31'd0, e.s_cyc});
            chk(e.name, "m0_ack", {31'd0, m0_ack}, {31'd0, e.a0});
            chk(e.name, "m0_err", {31'd0, m0_err}, {31'd0, e.e0});
            chk(e.name, "m1_ack", {31'd0, m1_ack}, {31'd0, e.a1});
            chk(e.name, "m1_err", {31'd0, m1_err}, {31'd0, e.e1});
            chk(e.name, "timeout", {31'd0, tmo},   {31'd0, e.t});
            chk(e.name, "t0_timeout", {31'd0, z_tmo}, 32'd0);
            chk(e.name, "t0_m0_err", {31'd0, z_m0_err}, {31'd0, e.ez});
            if (e.adr_en) chk(e.name, "s_adr", s_adr, e.adr);
            if (e.dat_en) chk(e.name, "m0_dat", m0_rd, e.dat);
        end
    end

    task automatic expect_out(input string n, input logic [1:0] g, input logic sc,
                              input logic a0, input logic e0, input logic a1,
                              input logic e1, input logic t, input logic ez,
                              input bit adr_en, input logic [31:0] adr,
                              input bit dat_en, input logic [31:0] dat);
        exp_t e;
        e.name = n; e.grant = g; e.s_cyc = sc;
        e.a0 = a0; e.e0 = e0; e.a1 = a1; e.e1 = e1; e.t = t; e.ez = ez;
        e.adr_en = adr_en; e.adr = adr; e.dat_en = dat_en; e.dat = dat;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 0; m0_dat = 32'h1111_0000;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = 0; m1_dat = 32'h2222_0000;
        s_dat_in = 0; s_ack = 0; s_err = 0;
        tick();
        do_reset();

        // Reset state; stray slave ACK/ERR with no owner is ignored
        s_ack = 1; s_err = 1;
        expect_out("reset", 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        tick();
        s_ack = 0; s_err = 0;

        // Single master read
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        expect_out("single_req", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("single_stb1", 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0);
        tick();
        s_ack = 1; s_dat_in = 32'hDEADBEEF;
        expect_out("single_ack", 2'b01, 1, 1, 0, 0, 0, 0, 0, 1, 32'h10, 1, 32'hDEADBEEF);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        expect_out("single_drop", 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("single_idle", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Tie right after reset: m0 first, turnaround, then m1
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        expect_out("tie_req", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("tie_m0", 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        tick();
        s_ack = 1; s_dat_in = 32'h0000_0100;
        expect_out("tie_m0_ack", 2'b01, 1, 1, 0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h100);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        expect_out("tie_m0_drop", 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("tie_turn", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Lock: m1 owns while m0 keeps requesting
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
        for (int i = 0; i < 20; i++) begin
            m1_adr = 32'h200 + 32'(i * 4);
            s_ack = (i % 2 == 1);
            expect_out("lock", 2'b10, 1, 0, 0, s_ack, 0, 0, 0, 1, m1_adr, 0, 0);
            tick();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        expect_out("lock_drop", 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        m1_cyc = 1; m1_stb = 1;
        expect_out("tie2_turn", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Second tie goes to m0; slave silent -> watchdog on 9th strobe cycle
        for (int i = 1; i <= 10; i++) begin
            expect_out("watchdog", 2'b01, 1, 0, (i == 9), 0, 0, (i == 9), 0,
                       1, 32'h300, 0, 0);
            tick();
        end

        // ACK and ERR together
        s_ack = 1; s_err = 1;
        expect_out("ack_err", 2'b01, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        s_ack = 0; s_err = 0;
        for (int i = 0; i < 8; i++) begin
            expect_out("wd_count", 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        // ACK in the expiry cycle suppresses the timeout
        s_ack = 1;
        expect_out("ack_at_limit", 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        s_ack = 0;
        expect_out("after_limit", 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Mid-cycle reset while m1 owns
        m0_cyc = 0; m0_stb = 0;
        expect_out("mr_drop", 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("mr_turn", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        m0_cyc = 1; m0_stb = 1;
        expect_out("mr_m1", 2'b10, 1, 0, 0, 0, 0, 0, 0, 1, m1_adr, 0, 0);
        tick();
        rst = 1;
        expect_out("mr_pre", 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
        expect_out("mr_post", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("mr_regrant", 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0);
        tick();

        tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
